soft_start_sequencer: RTL and testbench
=======================================

Name: soft_start_sequencer

Overview:
Sequences a saturating up/down duty counter to soft-start and soft-stop a PMIC converter rail. Ramps the duty reference from 0 to a programmed target one LSB per step period, holds it in regulation, ramps it back to 0 on disable, and forces it to 0 on fault. It sits between the rail enable/fault logic and the PWM generator's duty input.

Parameters:
WIDTH, 8, duty reference width in bits
STEP_DIV, 16, clock cycles per ramp step (>=1)
PG_DELAY, 32, clock cycles in REGULATE before pwr_good asserts (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  rail enable request (level)
target  in  WIDTH  regulation duty target
fault  in  1  rail fault (level; OV/OC/OT combined)
fault_clr  in  1  fault acknowledge (level)
duty  out  WIDTH  registered duty reference to PWM
pwr_good  out  1  rail in regulation for >= PG_DELAY cycles
busy  out  1  high in RAMP_UP or RAMP_DOWN
fault_flag  out  1  latched fault indicator
state  out  3  FSM state (IDLE=0, RAMP_UP=1, REGULATE=2, RAMP_DOWN=3, FAULT=4)

Behaviour:
- reset low (async): state=IDLE, duty=0, pwr_good=0, busy=0, fault_flag=0, prescaler=0, pg timer=0; target_q=0.
- All outputs registered; busy/state decode the state register.
- Prescaler counts 0..STEP_DIV-1 only in RAMP_UP/RAMP_DOWN and clears on every state entry; tick when it equals STEP_DIV-1. First step occurs STEP_DIV cycles after state entry.
- Priority each cycle: fault > fault_clr > en > target change > tick.
- IDLE: duty=0. en=1 & fault=0 -> RAMP_UP; target_q <= target.
- RAMP_UP: each cycle, if duty==target_q -> REGULATE (no tick needed). Otherwise on tick, duty +1 if below target_q, -1 if above. en=0 -> RAMP_DOWN, duty held.
- REGULATE: duty held; pg timer increments; pwr_good=1 from the cycle the timer reaches PG_DELAY, until exit. en=0 -> RAMP_DOWN; target != target_q -> RAMP_UP, target_q <= target. Either exit clears pwr_good and the pg timer on the next edge.
- RAMP_DOWN: on tick duty -1; when duty==0 -> IDLE. en=1 -> RAMP_UP from current duty (no reload to 0); target_q <= target.
- Any state, fault=1: next edge -> FAULT, duty=0, pwr_good=0, fault_flag=1.
- FAULT: duty=0. Exit to IDLE only when fault=0 & fault_clr=1 & en=0; fault_flag clears on that edge. fault_clr with en=1 is ignored.
- Arithmetic: duty saturates; never decrements below 0 or increments past 2^WIDTH-1; no wrap.
- target=0 with en=1: RAMP_UP for one cycle, then REGULATE; duty stays 0.
- Undefined state encodings -> IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE..FAULT), STATE_W=3.
- Sub-module ramp_counter: WIDTH-bit saturating up/down counter with en, up_dn, sync clear, async active-low reset. The FSM drives en=tick, up_dn and clear; ramp_counter owns duty.
- Prescaler and pg timer stay inline.

Test Plan (WIDTH=8, STEP_DIV=4, PG_DELAY=8):
1. Reset, then en=1, target=5 -> RAMP_UP; duty steps 1..5 every 4 clocks (duty=5 at cycle 20 after entry); REGULATE next cycle; pwr_good=1 8 cycles later; busy high only during ramp.
2. From case 1, en=0 -> pwr_good=0 next edge, RAMP_DOWN; duty 5->0 over 20 cycles; then IDLE, busy=0.
3. During RAMP_DOWN at duty=3, en=1 -> RAMP_UP; duty next becomes 4 (not 0); REGULATE again at duty=5.
4. fault=1 during RAMP_UP at duty=2 -> next edge duty=0, state=4, fault_flag=1. fault=0, en=1, fault_clr=1 -> stays FAULT. en=0, fault_clr=1 -> IDLE, fault_flag=0.
5. reset low mid-REGULATE (duty=5, pwr_good=1), asserted between clock edges -> duty=0, pwr_good=0, state=0 immediately, no clock edge required.
6. target=255 ramp -> duty stops at 255 with no wrap. Then in REGULATE, target changes to 250 -> RAMP_UP, pwr_good=0, duty 255->250, REGULATE, pwr_good again after 8 cycles.

Source files
------------

// File: rtl/soft_start_sequencer_pkg.sv
// Shared FSM encoding for the rail soft-start sequencer and its helpers.
// No logic of its own; constants and a state-class decode only.
package soft_start_sequencer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RAMP_UP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_REGULATE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

  function automatic logic is_ramp(input logic [STATE_W-1:0] s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/soft_start_sequencer_ramp_counter.sv
// Saturating up/down duty counter; one-cycle update, clear beats step.
// Holds at 0 and at all-ones rather than wrapping; never stalls its driver.
module soft_start_sequencer_ramp_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (up_dn) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/soft_start_sequencer.sv
// Soft-start/soft-stop sequencer: ramps duty one LSB per STEP_DIV cycles to target, holds, ramps down, zeroes on fault.
// All outputs registered (one-edge response to inputs); no handshake, inputs are sampled levels.
module soft_start_sequencer
  import soft_start_sequencer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 16,
  parameter int PG_DELAY = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   target,
  input  logic               fault,
  input  logic               fault_clr,
  output logic [WIDTH-1:0]   duty,
  output logic               pwr_good,
  output logic               busy,
  output logic               fault_flag,
  output logic [STATE_W-1:0] state
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PG_W  = $clog2(PG_DELAY + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PG_W-1:0]  PG_LAST  = PG_W'(PG_DELAY);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [PG_W-1:0]    pg_cnt_q, pg_cnt_d;
  logic               pwr_good_q, pwr_good_d;
  logic               fault_flag_q, fault_flag_d;

  logic               tick;
  logic               cnt_en;
  logic               cnt_up;
  logic               cnt_clr;
  logic [WIDTH-1:0]   duty_cnt;

  assign tick = (presc_q == PRE_LAST);

  // Priority: fault, then fault_clr (FAULT only), then en, then retarget, then step.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    fault_flag_d = fault_flag_q;
    cnt_en       = 1'b0;
    cnt_up       = 1'b0;
    cnt_clr      = 1'b0;

    if (fault) begin
      state_d      = ST_FAULT;
      fault_flag_d = 1'b1;
      cnt_clr      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (en) begin
            state_d  = ST_RAMP_UP;
            target_d = target;
          end
        end
        ST_RAMP_UP: begin
          if (!en) begin
            state_d = ST_RAMP_DOWN;
          end else if (duty_cnt == target_q) begin
            state_d = ST_REGULATE;
          end else if (tick) begin
            cnt_en = 1'b1;
            cnt_up = (duty_cnt < target_q);
          end
        end
        ST_REGULATE: begin
          if (!en) begin
            state_d = ST_RAMP_DOWN;
          end else if (target != target_q) begin
            state_d  = ST_RAMP_UP;
            target_d = target;
          end
        end
        ST_RAMP_DOWN: begin
          // Re-enable resumes from the present duty rather than restarting at 0.
          if (en) begin
            state_d  = ST_RAMP_UP;
            target_d = target;
          end else if (duty_cnt == '0) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            cnt_en = 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_clr = 1'b1;
          if (fault_clr && !en) begin
            state_d      = ST_IDLE;
            fault_flag_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Prescaler only runs while staying in a ramp state, so every entry restarts it.
  always_comb begin
    presc_d = '0;
    if ((state_d == state_q) && is_ramp(state_q)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    pg_cnt_d   = '0;
    pwr_good_d = 1'b0;
    if ((state_q == ST_REGULATE) && (state_d == ST_REGULATE)) begin
      pg_cnt_d   = (pg_cnt_q == PG_LAST) ? pg_cnt_q : pg_cnt_q + 1'b1;
      pwr_good_d = (pg_cnt_d == PG_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      presc_q      <= '0;
      pg_cnt_q     <= '0;
      pwr_good_q   <= 1'b0;
      fault_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      presc_q      <= presc_d;
      pg_cnt_q     <= pg_cnt_d;
      pwr_good_q   <= pwr_good_d;
      fault_flag_q <= fault_flag_d;
    end
  end

  soft_start_sequencer_ramp_counter #(
    .WIDTH (WIDTH)
  ) u_ramp_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .up_dn (cnt_up),
    .clear (cnt_clr),
    .cnt   (duty_cnt)
  );

  assign duty       = duty_cnt;
  assign pwr_good   = pwr_good_q;
  assign fault_flag = fault_flag_q;
  assign state      = state_q;
  assign busy       = is_ramp(state_q);

endmodule

// File: tb/tb_soft_start_sequencer.sv
// Directed bench for soft_start_sequencer (WIDTH=8, STEP_DIV=4, PG_DELAY=8).
// Stimulus queues cycle-stamped expectations; a monitor compares them after each edge.
module tb_soft_start_sequencer;
  import soft_start_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] duty;
  logic       pwr_good;
  logic       busy;
  logic       fault_flag;
  logic [2:0] state;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] duty;
    logic [2:0] st;
    logic       pg;
    logic       ff;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  soft_start_sequencer #(
    .WIDTH    (8),
    .STEP_DIV (4),
    .PG_DELAY (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .target     (target),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .duty       (duty),
    .pwr_good   (pwr_good),
    .busy       (busy),
    .fault_flag (fault_flag),
    .state      (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_now(input string name, input logic [7:0] d, input logic [2:0] s,
                           input logic pg, input logic ff);
    logic bz;
    bz = (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
    n_chk++;
    if (duty !== d || state !== s || pwr_good !== pg || fault_flag !== ff || busy !== bz) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got duty=%0d state=%0d pg=%0b busy=%0b ff=%0b, want duty=%0d state=%0d pg=%0b busy=%0b ff=%0b",
               name, cyc, duty, state, pwr_good, busy, fault_flag, d, s, pg, bz, ff);
    end
  endtask

  task automatic expect_at(input int k, input logic [7:0] d, input logic [2:0] s,
                           input logic pg, input logic ff, input string name);
    exp_t e;
    e.cyc  = cyc + k;
    e.duty = d;
    e.st   = s;
    e.pg   = pg;
    e.ff   = ff;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          check_now(exp_q[i].name, exp_q[i].duty, exp_q[i].st, exp_q[i].pg, exp_q[i].ff);
          exp_q.delete(i);
        end else if (exp_q[i].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s: expected at cycle %0d, not sampled (now %0d)", exp_q[i].name, exp_q[i].cyc, cyc);
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    step(2);
    expect_at(1, 8'd0, ST_IDLE, 1'b0, 1'b0, "reset_state");
    step(1);
    reset = 1'b1;
    step(1);

    // Ramp 0 -> 5, regulate, power-good after 8 cycles.
    target = 8'd5;
    en     = 1'b1;
    expect_at(1,  8'd0, ST_RAMP_UP,  1'b0, 1'b0, "ru_entry");
    expect_at(4,  8'd0, ST_RAMP_UP,  1'b0, 1'b0, "ru_before_tick");
    expect_at(5,  8'd1, ST_RAMP_UP,  1'b0, 1'b0, "ru_step1");
    expect_at(13, 8'd3, ST_RAMP_UP,  1'b0, 1'b0, "ru_step3");
    expect_at(21, 8'd5, ST_RAMP_UP,  1'b0, 1'b0, "ru_duty5");
    expect_at(22, 8'd5, ST_REGULATE, 1'b0, 1'b0, "reg_entry");
    expect_at(29, 8'd5, ST_REGULATE, 1'b0, 1'b0, "pg_not_yet");
    expect_at(30, 8'd5, ST_REGULATE, 1'b1, 1'b0, "pg_on");
    step(32);

    // Disable: ramp down 5 -> 0, then idle.
    en = 1'b0;
    expect_at(1,  8'd5, ST_RAMP_DOWN, 1'b0, 1'b0, "rd_entry");
    expect_at(5,  8'd4, ST_RAMP_DOWN, 1'b0, 1'b0, "rd_step1");
    expect_at(21, 8'd0, ST_RAMP_DOWN, 1'b0, 1'b0, "rd_zero");
    expect_at(22, 8'd0, ST_IDLE,      1'b0, 1'b0, "rd_idle");
    step(24);

    // Re-enable mid ramp-down resumes from the current duty.
    en = 1'b1;
    expect_at(22, 8'd5, ST_REGULATE, 1'b0, 1'b0, "reg_again");
    step(24);
    en = 1'b0;
    expect_at(9, 8'd3, ST_RAMP_DOWN, 1'b0, 1'b0, "rd_duty3");
    step(9);
    en = 1'b1;
    expect_at(1,  8'd3, ST_RAMP_UP,  1'b0, 1'b0, "reup_entry");
    expect_at(5,  8'd4, ST_RAMP_UP,  1'b0, 1'b0, "reup_duty4");
    expect_at(9,  8'd5, ST_RAMP_UP,  1'b0, 1'b0, "reup_duty5");
    expect_at(10, 8'd5, ST_REGULATE, 1'b0, 1'b0, "reup_reg");
    step(12);

    // Fault during ramp-up, clear ignored while enabled, then exit.
    en = 1'b0;
    step(24);
    en = 1'b1;
    expect_at(9, 8'd2, ST_RAMP_UP, 1'b0, 1'b0, "ru_duty2");
    step(9);
    fault = 1'b1;
    expect_at(1, 8'd0, ST_FAULT, 1'b0, 1'b1, "fault_entry");
    step(2);
    fault     = 1'b0;
    fault_clr = 1'b1;
    expect_at(1, 8'd0, ST_FAULT, 1'b0, 1'b1, "clr_with_en_1");
    expect_at(3, 8'd0, ST_FAULT, 1'b0, 1'b1, "clr_with_en_3");
    step(3);
    en = 1'b0;
    expect_at(1, 8'd0, ST_IDLE, 1'b0, 1'b0, "fault_exit");
    step(2);
    fault_clr = 1'b0;

    // Zero target: one cycle of ramp-up, straight to regulate.
    target = 8'd0;
    en     = 1'b1;
    expect_at(1, 8'd0, ST_RAMP_UP,  1'b0, 1'b0, "t0_ramp_up");
    expect_at(2, 8'd0, ST_REGULATE, 1'b0, 1'b0, "t0_regulate");
    step(3);
    en = 1'b0;
    expect_at(1, 8'd0, ST_RAMP_DOWN, 1'b0, 1'b0, "t0_ramp_down");
    expect_at(2, 8'd0, ST_IDLE,      1'b0, 1'b0, "t0_idle");
    step(3);

    // Asynchronous reset in regulation, between clock edges.
    target = 8'd5;
    en     = 1'b1;
    expect_at(30, 8'd5, ST_REGULATE, 1'b1, 1'b0, "pg_before_reset");
    step(31);
    #2;
    reset = 1'b0;
    #1;
    check_now("async_reset", 8'd0, ST_IDLE, 1'b0, 1'b0);
    en = 1'b0;
    expect_at(1, 8'd0, ST_IDLE, 1'b0, 1'b0, "reset_hold");
    @(negedge clk);
    reset = 1'b1;
    step(1);

    // Full-scale ramp saturates at 255, then retarget downward to 250.
    target = 8'd255;
    en     = 1'b1;
    expect_at(1021, 8'd255, ST_RAMP_UP,  1'b0, 1'b0, "fs_duty255");
    expect_at(1022, 8'd255, ST_REGULATE, 1'b0, 1'b0, "fs_regulate");
    expect_at(1030, 8'd255, ST_REGULATE, 1'b1, 1'b0, "fs_pg");
    expect_at(1039, 8'd255, ST_REGULATE, 1'b1, 1'b0, "fs_no_wrap");
    step(1040);
    target = 8'd250;
    expect_at(1,  8'd255, ST_RAMP_UP,  1'b0, 1'b0, "rt_entry");
    expect_at(5,  8'd254, ST_RAMP_UP,  1'b0, 1'b0, "rt_step1");
    expect_at(21, 8'd250, ST_RAMP_UP,  1'b0, 1'b0, "rt_duty250");
    expect_at(22, 8'd250, ST_REGULATE, 1'b0, 1'b0, "rt_regulate");
    expect_at(29, 8'd250, ST_REGULATE, 1'b0, 1'b0, "rt_pg_not_yet");
    expect_at(30, 8'd250, ST_REGULATE, 1'b1, 1'b0, "rt_pg");
    step(32);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
